// File: rtl/mold_pkg.sv
// Shared MoldUDP64 definitions: field widths, error codes and assembler states.
package mold_pkg;

  localparam int ML_W   = 16;
  localparam int KEEP_W = 8;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_OVERSIZE = 2'd1;
  localparam logic [1:0] ERR_TRUNC    = 2'd2;
  localparam logic [1:0] ERR_STRAY    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DROP
  } state_e;

endpackage

// File: rtl/cnt_ones_thermo.sv
// Counts the set bits of an LSB-first thermometer byte mask.
module cnt_ones_thermo #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  thermo_i,
  output logic [CW-1:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int j = 0; j < W; j++) begin
      count_o = count_o + CW'(thermo_i[j]);
    end
  end

endmodule

// File: rtl/mold_msg_assembler.sv
// Gathers the beats of one MoldUDP64 message into a flat buffer and presents
// each complete message, or an error pulse for a discarded one, to the ITCH decoder.
module mold_msg_assembler #(
  parameter int DATA_W    = 64,
  parameter int KEEP_W    = mold_pkg::KEEP_W,
  parameter int ML_W      = mold_pkg::ML_W,
  parameter int MAX_BYTES = 64
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   msg_v_i,
  input  logic                   msg_start_i,
  input  logic [ML_W-1:0]        msg_len_i,
  input  logic [KEEP_W-1:0]      msg_mask_i,
  input  logic [DATA_W-1:0]      msg_data_i,
  output logic                   itch_v_o,
  output logic [7:0]             itch_type_o,
  output logic [ML_W-1:0]        itch_len_o,
  output logic [MAX_BYTES*8-1:0] itch_data_o,
  output logic                   itch_err_o,
  output logic [1:0]             itch_err_code_o
);

  import mold_pkg::state_e;
  import mold_pkg::ST_IDLE;
  import mold_pkg::ST_COLLECT;
  import mold_pkg::ST_DROP;
  import mold_pkg::ERR_NONE;
  import mold_pkg::ERR_OVERSIZE;
  import mold_pkg::ERR_TRUNC;
  import mold_pkg::ERR_STRAY;

  localparam int PW = $clog2(KEEP_W + 1);
  localparam int CW = ML_W + 1;
  localparam int BW = MAX_BYTES * 8;
  localparam logic [ML_W-1:0] MAX_LEN = ML_W'(MAX_BYTES);

  state_e            state_q;
  logic [ML_W-1:0]   len_q;
  logic [ML_W-1:0]   cnt_q;
  logic [BW-1:0]     buf_q;
  logic              itch_v_q;
  logic [7:0]        itch_type_q;
  logic [ML_W-1:0]   itch_len_q;
  logic [BW-1:0]     itch_data_q;
  logic              itch_err_q;
  logic [1:0]        itch_err_code_q;

  logic [PW-1:0]     beatBytes;
  logic [ML_W-1:0]   base;
  logic [ML_W-1:0]   lenCur;
  logic [CW-1:0]     sumWide;
  logic [ML_W-1:0]   cnt_d;
  logic              reach;
  logic              writeEn;
  logic [BW-1:0]     buf_d;

  cnt_ones_thermo #(.W(KEEP_W), .CW(PW)) u_popcount (
    .thermo_i (msg_mask_i),
    .count_o  (beatBytes)
  );

  // A start beat restarts at offset 0 against its own length; otherwise the
  // beat continues at the running byte count of the latched message.
  always_comb begin
    base    = msg_start_i ? '0 : cnt_q;
    lenCur  = msg_start_i ? msg_len_i : len_q;
    sumWide = {1'b0, base} + CW'(beatBytes);
    cnt_d   = sumWide[ML_W] ? '1 : sumWide[ML_W-1:0];
    reach   = sumWide >= {1'b0, lenCur};
    writeEn = msg_start_i ? (msg_len_i != '0 && msg_len_i <= MAX_LEN)
                          : (state_q == ST_COLLECT);
    buf_d   = msg_start_i ? '0 : buf_q;
    for (int i = 0; i < MAX_BYTES; i++) begin
      for (int j = 0; j < KEEP_W; j++) begin
        if (writeEn && msg_mask_i[j] && (({1'b0, base} + CW'(j)) == CW'(i))
            && (CW'(i) < {1'b0, lenCur})) begin
          buf_d[8*i +: 8] = msg_data_i[8*j +: 8];
        end
      end
    end
  end

  // Message FSM; every output is a register so the decoder sees clean pulses.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q         <= ST_IDLE;
      len_q           <= '0;
      cnt_q           <= '0;
      buf_q           <= '0;
      itch_v_q        <= 1'b0;
      itch_type_q     <= '0;
      itch_len_q      <= '0;
      itch_data_q     <= '0;
      itch_err_q      <= 1'b0;
      itch_err_code_q <= ERR_NONE;
    end else begin
      itch_v_q        <= 1'b0;
      itch_err_q      <= 1'b0;
      itch_err_code_q <= ERR_NONE;
      if (msg_v_i) begin
        if (msg_start_i) begin
          len_q <= msg_len_i;
          cnt_q <= cnt_d;
          buf_q <= buf_d;
          if (state_q == ST_COLLECT) begin
            itch_err_q      <= 1'b1;
            itch_err_code_q <= ERR_TRUNC;
          end else if (state_q == ST_DROP) begin
            itch_err_q      <= 1'b1;
            itch_err_code_q <= ERR_OVERSIZE;
          end
          if (msg_len_i == '0) begin
            state_q <= ST_IDLE;
            if (state_q == ST_IDLE) begin
              itch_err_q      <= 1'b1;
              itch_err_code_q <= ERR_STRAY;
            end
          end else if (msg_len_i > MAX_LEN) begin
            state_q <= ST_DROP;
          end else if (reach) begin
            state_q     <= ST_IDLE;
            itch_v_q    <= 1'b1;
            itch_type_q <= buf_d[7:0];
            itch_len_q  <= lenCur;
            itch_data_q <= buf_d;
          end else begin
            state_q <= ST_COLLECT;
          end
        end else begin
          case (state_q)
            ST_COLLECT: begin
              cnt_q <= cnt_d;
              buf_q <= buf_d;
              if (reach) begin
                state_q     <= ST_IDLE;
                itch_v_q    <= 1'b1;
                itch_type_q <= buf_d[7:0];
                itch_len_q  <= lenCur;
                itch_data_q <= buf_d;
              end
            end
            ST_DROP: begin
              cnt_q <= cnt_d;
              if (reach) begin
                state_q         <= ST_IDLE;
                itch_err_q      <= 1'b1;
                itch_err_code_q <= ERR_OVERSIZE;
              end
            end
            default: begin
              itch_err_q      <= 1'b1;
              itch_err_code_q <= ERR_STRAY;
            end
          endcase
        end
      end
    end
  end

  assign itch_v_o        = itch_v_q;
  assign itch_type_o     = itch_type_q;
  assign itch_len_o      = itch_len_q;
  assign itch_data_o     = itch_data_q;
  assign itch_err_o      = itch_err_q;
  assign itch_err_code_o = itch_err_code_q;

endmodule
